// File: rtl/acq_ctrl_if.sv
// Bus bundle for acq_ctrl: control pulses, ADC stream, buffer RAM ports and readback.
// The slave modport is the controller's view; master is the driver/RAM side.
interface acq_ctrl_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 10
);
   logic              start;
   logic              abort;
   logic              trig;
   logic [ADDR_W:0]   len;
   logic [DATA_W-1:0] adc_data;
   logic              adc_valid;
   logic              rd_en;

   logic              busy;
   logic              done;
   logic [ADDR_W:0]   wr_count;

   logic              ram_wr;
   logic [ADDR_W-1:0] ram_waddr;
   logic [DATA_W-1:0] ram_wdata;
   logic              ram_rd;
   logic [ADDR_W-1:0] ram_raddr;
   logic [DATA_W-1:0] ram_rdata;

   logic              rd_valid;
   logic [DATA_W-1:0] rd_data;
   logic              rd_last;

   modport slave (
      input  start, abort, trig, len, adc_data, adc_valid, rd_en, ram_rdata,
      output busy, done, wr_count,
      output ram_wr, ram_waddr, ram_wdata, ram_rd, ram_raddr,
      output rd_valid, rd_data, rd_last
   );

   modport master (
      output start, abort, trig, len, adc_data, adc_valid, rd_en, ram_rdata,
      input  busy, done, wr_count,
      input  ram_wr, ram_waddr, ram_wdata, ram_rd, ram_raddr,
      input  rd_valid, rd_data, rd_last
   );
endinterface

// File: rtl/acq_ctrl.sv
// Triggered acquisition controller: arms on start, fills a buffer RAM with len samples
// after a trigger, then replays the buffer circularly on rd_en.
module acq_ctrl #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 10
) (
   input  logic      clk,
   input  logic      rst_n,
   acq_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      ACQ   = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [ADDR_W:0]   DEPTH   = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

   state_t            state_q,     state_d;
   logic [ADDR_W:0]   len_q,       len_d;
   logic [ADDR_W:0]   wr_count_q,  wr_count_d;
   logic [ADDR_W-1:0] wptr_q,      wptr_d;
   logic [ADDR_W-1:0] rptr_q,      rptr_d;
   logic              ram_wr_q,    ram_wr_d;
   logic [ADDR_W-1:0] ram_waddr_q, ram_waddr_d;
   logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
   logic              rd_valid_q,  rd_valid_d;
   logic              rd_last_q,   rd_last_d;

   logic [ADDR_W:0]   last_idx;
   logic [ADDR_W:0]   len_clamped;
   logic              start_ok;
   logic              wr_final;
   logic              rd_at_last;
   logic              rd_ok;

   // A read is blocked only when it would hit the location still being written,
   // which can happen solely on the first DONE cycle of a one-sample capture.
   always_comb begin
      last_idx    = len_q - CNT_ONE;
      len_clamped = (bus.len == '0 || bus.len > DEPTH) ? DEPTH : bus.len;
      start_ok    = bus.start && !bus.abort && (state_q == IDLE || state_q == DONE);
      wr_final    = (wr_count_q == last_idx);
      rd_at_last  = ({1'b0, rptr_q} == last_idx);
      rd_ok       = rst_n && (state_q == DONE) && bus.rd_en &&
                    !(ram_wr_q && (ram_waddr_q == rptr_q));
   end

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      wr_count_d  = wr_count_q;
      wptr_d      = wptr_q;
      rptr_d      = rptr_q;
      ram_wr_d    = 1'b0;
      ram_waddr_d = ram_waddr_q;
      ram_wdata_d = ram_wdata_q;
      rd_valid_d  = 1'b0;
      rd_last_d   = 1'b0;

      if (bus.abort) begin
         state_d = IDLE;
      end else if (start_ok) begin
         state_d    = ARMED;
         len_d      = len_clamped;
         wr_count_d = '0;
         wptr_d     = '0;
      end else begin
         case (state_q)
            IDLE: begin
            end
            ARMED: begin
               if (bus.trig) begin
                  state_d = ACQ;
               end
            end
            ACQ: begin
               // The pointer holds on the final sample so it never passes len_q-1.
               if (bus.adc_valid) begin
                  ram_wr_d    = 1'b1;
                  ram_waddr_d = wptr_q;
                  ram_wdata_d = bus.adc_data;
                  wr_count_d  = wr_count_q + CNT_ONE;
                  if (wr_final) begin
                     state_d = DONE;
                     rptr_d  = '0;
                  end else begin
                     wptr_d = wptr_q + PTR_ONE;
                  end
               end
            end
            DONE: begin
               if (rd_ok) begin
                  rd_valid_d = 1'b1;
                  rd_last_d  = rd_at_last;
                  rptr_d     = rd_at_last ? '0 : rptr_q + PTR_ONE;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         len_q       <= '0;
         wr_count_q  <= '0;
         wptr_q      <= '0;
         rptr_q      <= '0;
         ram_wr_q    <= 1'b0;
         ram_waddr_q <= '0;
         ram_wdata_q <= '0;
         rd_valid_q  <= 1'b0;
         rd_last_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         wr_count_q  <= wr_count_d;
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         ram_wr_q    <= ram_wr_d;
         ram_waddr_q <= ram_waddr_d;
         ram_wdata_q <= ram_wdata_d;
         rd_valid_q  <= rd_valid_d;
         rd_last_q   <= rd_last_d;
      end
   end

   assign bus.busy      = (state_q == ARMED) || (state_q == ACQ);
   assign bus.done      = (state_q == DONE);
   assign bus.wr_count  = wr_count_q;
   assign bus.ram_wr    = ram_wr_q;
   assign bus.ram_waddr = ram_waddr_q;
   assign bus.ram_wdata = ram_wdata_q;
   assign bus.ram_rd    = rd_ok;
   assign bus.ram_raddr = rptr_q;
   assign bus.rd_valid  = rd_valid_q;
   assign bus.rd_data   = bus.ram_rdata;
   assign bus.rd_last   = rd_last_q;

   a_no_rw_collision: assert property (@(posedge clk) disable iff (!rst_n)
      !(bus.ram_wr && bus.ram_rd && (bus.ram_waddr == bus.ram_raddr)));

   a_wptr_in_range: assert property (@(posedge clk) disable iff (!rst_n)
      (state_q == IDLE) || ({1'b0, wptr_q} <= last_idx));

endmodule

// File: tb/tb_acq_ctrl.sv
// Scoreboard bench for acq_ctrl: directed stimulus pushes expected RAM writes and
// readback words into queues; a negedge monitor pops and compares them.
module tb_acq_ctrl;

   localparam int ADDR_W = 4;
   localparam int DATA_W = 10;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_exp_t;

   typedef struct {
      logic [DATA_W-1:0] data;
      logic              last;
   } rd_exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   int compared   = 0;
   int mismatched = 0;

   wr_exp_t wr_q[$];
   rd_exp_t rd_q[$];
   wr_exp_t wr_m;
   rd_exp_t rd_m;

   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

   always #5 clk = ~clk;

   acq_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   acq_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Buffer RAM model: registered read, data valid the cycle after ram_rd.
   always @(posedge clk) begin
      if (bus.ram_wr) mem[bus.ram_waddr] <= bus.ram_wdata;
      if (bus.ram_rd) bus.ram_rdata <= mem[bus.ram_raddr];
   end

   // Monitor: every presented write or readback word must match the head of its queue.
   always @(negedge clk) begin
      if (bus.ram_wr === 1'b1) begin
         compared++;
         if (wr_q.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL unexpected_write: got addr=%0h data=%0h, required no write",
                     bus.ram_waddr, bus.ram_wdata);
         end else begin
            wr_m = wr_q.pop_front();
            if (bus.ram_waddr !== wr_m.addr || bus.ram_wdata !== wr_m.data) begin
               mismatched++;
               $display("[TB] FAIL ram_write: got addr=%0h data=%0h, required addr=%0h data=%0h",
                        bus.ram_waddr, bus.ram_wdata, wr_m.addr, wr_m.data);
            end
         end
      end
      if (bus.rd_valid === 1'b1) begin
         compared++;
         if (rd_q.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL unexpected_rd_valid: got data=%0h last=%0b, required no word",
                     bus.rd_data, bus.rd_last);
         end else begin
            rd_m = rd_q.pop_front();
            if (bus.rd_data !== rd_m.data || bus.rd_last !== rd_m.last) begin
               mismatched++;
               $display("[TB] FAIL readback: got data=%0h last=%0b, required data=%0h last=%0b",
                        bus.rd_data, bus.rd_last, rd_m.data, rd_m.last);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic st, input logic ab, input logic tr,
                                input logic [ADDR_W:0] ln, input logic [DATA_W-1:0] d,
                                input logic v, input logic re);
      bus.start     = st;
      bus.abort     = ab;
      bus.trig      = tr;
      bus.len       = ln;
      bus.adc_data  = d;
      bus.adc_valid = v;
      bus.rd_en     = re;
      tick();
   endtask

   task automatic idleCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
      end
   endtask

   task automatic expectWrite(input int addr, input int data);
      wr_q.push_back('{addr: ADDR_W'(addr), data: DATA_W'(data)});
   endtask

   task automatic expectRead(input int data, input logic last);
      rd_q.push_back('{data: DATA_W'(data), last: last});
   endtask

   task automatic checkReset(input string tag);
      checkOutput({tag, "_busy"},      32'(bus.busy),      32'd0);
      checkOutput({tag, "_done"},      32'(bus.done),      32'd0);
      checkOutput({tag, "_wr_count"},  32'(bus.wr_count),  32'd0);
      checkOutput({tag, "_ram_wr"},    32'(bus.ram_wr),    32'd0);
      checkOutput({tag, "_ram_rd"},    32'(bus.ram_rd),    32'd0);
      checkOutput({tag, "_rd_valid"},  32'(bus.rd_valid),  32'd0);
      checkOutput({tag, "_rd_last"},   32'(bus.rd_last),   32'd0);
      checkOutput({tag, "_ram_waddr"}, 32'(bus.ram_waddr), 32'd0);
      checkOutput({tag, "_ram_wdata"}, 32'(bus.ram_wdata), 32'd0);
   endtask

   initial begin
      $display("[TB] acq_ctrl bench start");
      bus.start = 1'b0; bus.abort = 1'b0; bus.trig = 1'b0; bus.len = '0;
      bus.adc_data = '0; bus.adc_valid = 1'b0; bus.rd_en = 1'b1;
      rst_n = 1'b0;
      repeat (3) tick();
      checkReset("reset");
      rst_n = 1'b1;
      idleCycle();

      // Length 4, six samples offered: only the first four land.
      applyStimulus(1'b1, 1'b0, 1'b0, 5'd4, '0, 1'b0, 1'b0);
      checkOutput("armed_busy", 32'(bus.busy), 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b1, '0, '0, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         if (i < 4) expectWrite(i, 'h11 + i);
         applyStimulus(1'b0, 1'b0, 1'b0, '0, DATA_W'('h11 + i), 1'b1, 1'b0);
      end
      idleCycle();
      checkOutput("len4_done",     32'(bus.done),     32'd1);
      checkOutput("len4_busy",     32'(bus.busy),     32'd0);
      checkOutput("len4_wr_count", 32'(bus.wr_count), 32'd4);

      // Readback wraps after the last address.
      for (int i = 0; i < 5; i++) begin
         expectRead('h11 + (i % 4), i == 3);
         applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
      end
      idleCycle();
      idleCycle();
      checkOutput("len4_rd_drained", 32'(rd_q.size()), 32'd0);

      // len=0 clamps to full depth.
      applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, '0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, '0, '0, 1'b0, 1'b0);
      for (int i = 0; i < 16; i++) begin
         expectWrite(i, 'h100 + i);
         applyStimulus(1'b0, 1'b0, 1'b0, '0, DATA_W'('h100 + i), 1'b1, 1'b0);
      end
      idleCycle();
      checkOutput("len0_done",     32'(bus.done),     32'd1);
      checkOutput("len0_wr_count", 32'(bus.wr_count), 32'd16);

      // len=17 clamps to full depth; 17th sample is dropped.
      applyStimulus(1'b1, 1'b0, 1'b0, 5'd17, '0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, '0, '0, 1'b0, 1'b0);
      for (int i = 0; i < 17; i++) begin
         if (i < 16) expectWrite(i, 'h200 + i);
         applyStimulus(1'b0, 1'b0, 1'b0, '0, DATA_W'('h200 + i), 1'b1, 1'b0);
      end
      idleCycle();
      checkOutput("len17_done",     32'(bus.done),     32'd1);
      checkOutput("len17_wr_count", 32'(bus.wr_count), 32'd16);
      for (int i = 0; i < 17; i++) begin
         expectRead('h200 + (i % 16), i == 15);
         applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
      end
      idleCycle();
      idleCycle();

      // Sample coinciding with the trigger is not captured.
      applyStimulus(1'b1, 1'b0, 1'b0, 5'd2, '0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, '0, DATA_W'('hAA), 1'b1, 1'b0);
      expectWrite(0, 'h21);
      expectWrite(1, 'h22);
      applyStimulus(1'b0, 1'b0, 1'b0, '0, DATA_W'('h21), 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, '0, DATA_W'('h22), 1'b1, 1'b0);
      idleCycle();
      checkOutput("trig_done",     32'(bus.done),     32'd1);
      checkOutput("trig_wr_count", 32'(bus.wr_count), 32'd2);
      expectRead('h21, 1'b0);
      expectRead('h22, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
      idleCycle();

      // Abort after two of eight samples cancels the write in flight.
      applyStimulus(1'b1, 1'b0, 1'b0, 5'd8, '0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, '0, '0, 1'b0, 1'b0);
      expectWrite(0, 'h31);
      expectWrite(1, 'h32);
      applyStimulus(1'b0, 1'b0, 1'b0, '0, DATA_W'('h31), 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, '0, DATA_W'('h32), 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, '0, DATA_W'('h33), 1'b1, 1'b0);
      checkOutput("abort_busy",   32'(bus.busy),   32'd0);
      checkOutput("abort_done",   32'(bus.done),   32'd0);
      checkOutput("abort_ram_wr", 32'(bus.ram_wr), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, '0, DATA_W'('h34), 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, '0, DATA_W'('h35), 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 5'd4, '0, 1'b0, 1'b0);
      checkOutput("abort_start_busy", 32'(bus.busy), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b1, '0, DATA_W'('h36), 1'b1, 1'b0);
      checkOutput("abort_start_idle", 32'(bus.busy), 32'd0);

      // Starts during ARMED/ACQ are ignored; reset mid-capture drops it.
      applyStimulus(1'b1, 1'b0, 1'b0, 5'd8, '0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 5'd2, '0, 1'b0, 1'b0);
      checkOutput("armed_start_busy", 32'(bus.busy), 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b1, '0, '0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         expectWrite(i, 'h41 + i);
         applyStimulus(1'b0, 1'b0, 1'b0, '0, DATA_W'('h41 + i), 1'b1, 1'b0);
      end
      applyStimulus(1'b1, 1'b0, 1'b0, 5'd2, '0, 1'b0, 1'b0);
      checkOutput("acq_start_wr_count", 32'(bus.wr_count), 32'd3);
      checkOutput("acq_start_busy",     32'(bus.busy),     32'd1);
      rst_n = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, '0, DATA_W'('h44), 1'b1, 1'b1);
      checkReset("midacq_reset");
      applyStimulus(1'b0, 1'b0, 1'b0, '0, DATA_W'('h45), 1'b1, 1'b1);
      checkOutput("reset_hold_ram_rd", 32'(bus.ram_rd), 32'd0);
      rst_n = 1'b1;
      idleCycle();
      idleCycle();

      checkOutput("wr_queue_drained", 32'(wr_q.size()), 32'd0);
      checkOutput("rd_queue_drained", 32'(rd_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
